mem_port_arbiter: RTL

//  Shares one single-port synchronous word memory (1-cycle read latency) between the core's instruction fetch and load/store ports.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/arb_sat_counter.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and default sizes for the memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  localparam int ADDR_W_DEF     = 10;
  localparam int CNT_W_DEF      = 16;
  localparam int STARVE_MAX_DEF = 4;

  // Who owns the read data coming back from memory next cycle
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

endpackage
`default_nettype wire

// File: rtl/arb_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : arb_sat_counter
// Description : Saturating up-counter with synchronous clear and synchronous
//               active-low reset. Holds at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear wins over increment; increment stops at all-ones
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port 1-cycle-latency word memory between
//               instruction fetch and load/store. One grant per cycle, data
//               has priority, read data is routed back by a registered owner
//               tag, and cycles with both ports requesting are counted.
//               Optional macro ARB_STARVE_GUARD_EN: after STARVE_MAX denied
//               fetch cycles, fetch wins the next conflict once.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  owner_e owner_q;
  owner_e owner_d;
  logic   force_if;

`ifdef ARB_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  logic [STARVE_W-1:0] starve_cnt;

  // Counts consecutive denied fetch cycles; any fetch grant or idle fetch clears it
  arb_sat_counter #(
    .WIDTH (STARVE_W)
  ) u_starve_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (if_req & ~if_gnt),
    .clr   (if_gnt | ~if_req),
    .count (starve_cnt)
  );

  assign force_if = if_req && (starve_cnt >= STARVE_W'(STARVE_MAX));
`else
  assign force_if = 1'b0;
`endif

  // Grant selection and memory request mux; reset low suppresses every grant
  always_comb begin
    d_gnt     = 1'b0;
    if_gnt    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    owner_d   = OWN_NONE;
    if (reset) begin
      if (d_req && !force_if) begin
        d_gnt    = 1'b1;
        mem_en   = 1'b1;
        mem_addr = d_addr;
        if (d_we) begin
          mem_we    = d_be;
          mem_wdata = d_wdata;
        end else begin
          owner_d = OWN_D;
        end
      end else if (if_req) begin
        if_gnt   = 1'b1;
        mem_en   = 1'b1;
        mem_addr = if_addr;
        owner_d  = OWN_IF;
      end
    end
  end

  // Owner tag of the access whose read data arrives next cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign if_rvalid = (owner_q == OWN_IF);
  assign d_rvalid  = (owner_q == OWN_D);
  assign if_rdata  = if_rvalid ? mem_rdata : 32'h0;
  assign d_rdata   = d_rvalid  ? mem_rdata : 32'h0;

  // Contention statistics: cycles with both ports requesting
  arb_sat_counter #(
    .WIDTH (CNT_W)
  ) u_conflict_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (if_req & d_req),
    .clr   (1'b0),
    .count (conflict_cnt)
  );

endmodule
`default_nettype wire
